axi_sink: RTL and testbench

// - Write-side counterpart of axi_source: packs a per-pixel WIDTH-bit stream (dark-mode mask bytes) into 64-bit words.
// - Buffers the packed words and writes them to DDR with fixed-length AXI3 INCR bursts, starting at addr_i on each frame.
// - Fills the frame buffer that the overlay read path (axi_source -> overlay) fetches one frame later.
// - AXI write channels only; the read channels belong to axi_source.

---
 rtl/axi_sink.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_sink.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sink.sv
// axi_sink: packs a WIDTH-bit item stream into 64-bit words and writes them to DDR in fixed AXI3 INCR bursts.
// Optional feature macro: AXI_SINK_BRESP_CHECK_EN (sticky err_o plus a saturating error-response counter).
`default_nettype none

module axi_sink #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 1920*1080,
    parameter int BURST   = 16,
    parameter int FIFO_AW = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             aval_i,
    input  logic [31:0]      addr_i,
    input  logic             val_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             overflow_o,
    output logic             err_o,

    input  logic             m_axi_awready,
    input  logic             m_axi_wready,
    input  logic             m_axi_bvalid,
    input  logic [1:0]       m_axi_bresp,
    input  logic [5:0]       m_axi_bid,

    output logic             m_axi_awvalid,
    output logic [31:0]      m_axi_awaddr,
    output logic [3:0]       m_axi_awlen,
    output logic [2:0]       m_axi_awsize,
    output logic [1:0]       m_axi_awburst,
    output logic [3:0]       m_axi_awcache,
    output logic [2:0]       m_axi_awprot,
    output logic [1:0]       m_axi_awlock,
    output logic [3:0]       m_axi_awqos,
    output logic [5:0]       m_axi_awid,
    output logic             m_axi_wvalid,
    output logic [63:0]      m_axi_wdata,
    output logic [7:0]       m_axi_wstrb,
    output logic             m_axi_wlast,
    output logic [5:0]       m_axi_wid,
    output logic             m_axi_bready
);

    localparam int N   = 64 / WIDTH;
    localparam int PCW = (N > 1) ? $clog2(N) : 1;
    localparam int ICW = $clog2(SIZE + 1);

    localparam logic [PCW-1:0]     PACK_LAST = PCW'(N - 1);
    localparam logic [PCW-1:0]     PACK_ONE  = PCW'(1);
    localparam logic [ICW-1:0]     ITEM_MAX  = ICW'(SIZE);
    localparam logic [ICW-1:0]     ITEM_ONE  = ICW'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   BURST_LVL = (FIFO_AW+1)'(BURST);
    localparam logic [31:0]        ADDR_INC  = 32'(8 * BURST);
    localparam logic [4:0]         BEAT_PRE  = 5'(BURST - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;

    logic             aval_q;
    logic             pending;
    logic             flush;

    logic [PCW-1:0]   pack_cnt;
    logic [ICW-1:0]   item_cnt;
    logic [63:0]      word;
    logic             push;
    logic             accept;

    logic [63:0]      mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] level;
    logic             full;
    logic             pop;
    logic             do_push;

    logic [4:0]       beat;

    // A restart is only acted on between bursts so the interconnect never sees a cut burst.
    assign flush   = pending && (state == IDLE);
    assign accept  = en_i && val_i && !pending && (item_cnt != ITEM_MAX);
    assign level   = wr_ptr - rd_ptr;
    assign full    = level[FIFO_AW];
    assign pop     = (state == DATA) && m_axi_wvalid && m_axi_wready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            aval_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            aval_q <= aval_i;
            if (aval_i && !aval_q)
                pending <= 1'b1;
            else if (flush)
                pending <= 1'b0;
        end
    end

    // The word register is written little-endian; the completed word is pushed a cycle later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pack_cnt <= '0;
            item_cnt <= '0;
            word     <= '0;
            push     <= 1'b0;
        end else if (flush) begin
            pack_cnt <= '0;
            item_cnt <= '0;
            push     <= 1'b0;
        end else begin
            push <= accept && (pack_cnt == PACK_LAST);
            if (accept) begin
                word[int'(pack_cnt)*WIDTH +: WIDTH] <= data_i;
                pack_cnt <= (pack_cnt == PACK_LAST) ? '0 : pack_cnt + PACK_ONE;
                item_cnt <= item_cnt + ITEM_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush)
            mem[wr_ptr[FIFO_AW-1:0]] <= word;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && full && !pop)
                overflow_o <= 1'b1;
        end
    end

    assign m_axi_wdata = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            beat          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        m_axi_awaddr <= addr_i;
                        beat         <= '0;
                    end else if (level >= BURST_LVL) begin
                        m_axi_awvalid <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_awaddr  <= m_axi_awaddr + ADDR_INC;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (BURST == 1);
                        beat          <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_wready) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= RESP;
                        end else begin
                            beat        <= beat + 5'd1;
                            m_axi_wlast <= (beat == BEAT_PRE);
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_SINK_BRESP_CHECK_EN
    (* mark_debug = "true" *) logic [15:0] bresp_err_cnt;
    logic unused_bid;

    assign unused_bid = &{1'b0, m_axi_bid};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o         <= 1'b0;
            bresp_err_cnt <= '0;
        end else if ((state == RESP) && m_axi_bready && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
            err_o <= 1'b1;
            if (bresp_err_cnt != 16'hFFFF)
                bresp_err_cnt <= bresp_err_cnt + 16'd1;
        end
    end
`else
    logic unused_resp;

    assign unused_resp = &{1'b0, m_axi_bresp, m_axi_bid};
    assign err_o       = 1'b0;
`endif

    assign m_axi_awlen   = 4'(BURST - 1);
    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awlock  = 2'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awid    = 6'd0;
    assign m_axi_wid     = 6'd0;
    assign m_axi_wstrb   = 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_axi_sink.sv
// tb_axi_sink: randomized bench for axi_sink with a queue-based word model and an AXI write slave.
`default_nettype none

module tb_axi_sink;

    localparam int SIZE  = 1024;
    localparam int BURST = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, aval = 1'b0, val = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  data = '0;
    logic        awready = 1'b1, wready = 1'b1, bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic [5:0]  bid = '0;

    logic        overflow, err;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic [31:0] m_axi_awaddr;
    logic [3:0]  m_axi_awlen, m_axi_awcache, m_axi_awqos;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst, m_axi_awlock;
    logic [5:0]  m_axi_awid, m_axi_wid;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;

    axi_sink #(.WIDTH(8), .SIZE(SIZE), .BURST(BURST), .FIFO_AW(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .aval_i(aval), .addr_i(addr),
        .val_i(val), .data_i(data), .overflow_o(overflow), .err_o(err),
        .m_axi_awready(awready), .m_axi_wready(wready), .m_axi_bvalid(bvalid),
        .m_axi_bresp(bresp), .m_axi_bid(bid),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awlock(m_axi_awlock), .m_axi_awqos(m_axi_awqos),
        .m_axi_awid(m_axi_awid), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wid(m_axi_wid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the byte stream of the current frame, grouped into words in arrival order.
    logic [63:0] exp_q[$];
    logic [63:0] cur_word;
    int          cur_cnt, frame_items;
    logic [31:0] exp_addr;

    task automatic model_restart(input logic [31:0] base);
        exp_q.delete();
        cur_word    = '0;
        cur_cnt     = 0;
        frame_items = 0;
        exp_addr    = base;
    endtask

    task automatic model_item(input logic [7:0] d);
        if (frame_items < SIZE) begin
            frame_items++;
            cur_word[cur_cnt*8 +: 8] = d;
            cur_cnt++;
            if (cur_cnt == 8) begin
                exp_q.push_back(cur_word);
                cur_cnt = 0;
            end
        end
    endtask

    // AXI slave behaviour knobs
    int         aw_delay = 0, aw_cnt = 0;
    int         wmode = 0;
    logic [1:0] resp_next = 2'b00;

    initial forever begin
        @(posedge clk); #1;
        if (aw_delay == 0) awready = 1'b1;
        else if (!m_axi_awvalid) begin aw_cnt = 0; awready = 1'b0; end
        else if (aw_cnt < aw_delay) begin aw_cnt++; awready = 1'b0; end
        else awready = 1'b1;
    end

    initial forever begin
        @(posedge clk); #1;
        wready = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial forever begin
        logic lasths, bhs;
        @(negedge clk);
        lasths = m_axi_wvalid && wready && m_axi_wlast;
        bhs    = bvalid && m_axi_bready;
        @(posedge clk); #1;
        if (bhs) bvalid = 1'b0;
        if (lasths) begin bvalid = 1'b1; bresp = resp_next; end
    end

    // Monitor / scoreboard
    logic        chk_en = 1'b0;
    int          bursts = 0, aw_wait = 0, max_wait = 0, beat = 0, last_beats = 0, b_hs = 0;
    logic        first_pending = 1'b0;
    logic [63:0] first_wdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [63:0] exp_w;
            if (bvalid && m_axi_bready) b_hs++;
            if (m_axi_awvalid) begin
                if (!awready) aw_wait++;
                else begin
                    if (chk_en) begin
                        check("awaddr", m_axi_awaddr, exp_addr);
                        check("awlen", m_axi_awlen, BURST - 1);
                    end
                    exp_addr += 32'(8 * BURST);
                    bursts++;
                    if (aw_wait > max_wait) max_wait = aw_wait;
                    aw_wait = 0;
                end
            end
            if (m_axi_wvalid && wready) begin
                if (chk_en) begin
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_axi_wdata;
                    check("wdata", m_axi_wdata, exp_w);
                    check("wlast", m_axi_wlast, (beat == BURST - 1));
                    if (first_pending) begin first_wdata = m_axi_wdata; first_pending = 1'b0; end
                end
                if (m_axi_wlast) begin last_beats = beat + 1; beat = 0; end
                else beat++;
            end
        end
    end

    task automatic pulse_aval(input logic [31:0] base);
        @(posedge clk); #1;
        addr = base; aval = 1'b1;
        repeat (2) @(posedge clk);
        #1 aval = 1'b0;
    endtask

    task automatic restart(input logic [31:0] base);
        pulse_aval(base);
        repeat (4) @(posedge clk);
        model_restart(base);
    endtask

    task automatic send_items(input int n, input bit rnd);
        int i = 0;
        while (i < n) begin
            logic v, e;
            logic [7:0] d;
            @(posedge clk); #1;
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            e = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            d = rnd ? 8'($urandom) : 8'(i);
            val = v; en = e; data = d;
            if (v && e) begin model_item(d); i++; end
        end
        @(posedge clk); #1;
        val = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bvalid || m_axi_bready || m_axi_awvalid || m_axi_wvalid) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("drain_in_time", (t < 5000), 1);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int b0, t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_wlast", m_axi_wlast, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        check("const_wstrb", m_axi_wstrb, 8'hFF);
        check("const_awsize", m_axi_awsize, 3);
        check("const_awburst", m_axi_awburst, 1);
        check("const_awcache", m_axi_awcache, 4'b0011);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single burst of an incrementing byte pattern
        restart(32'h2100_0000);
        chk_en = 1'b1; first_pending = 1'b1; b0 = bursts;
        send_items(128, 1'b0);
        wait_drain();
        check("t1_bursts", bursts - b0, 1);
        check("t1_beat0", first_wdata, 64'h0706050403020100);
        check("t1_overflow", overflow, 0);

        // Address-channel back-pressure
        restart(32'h2100_0000);
        aw_delay = 5; max_wait = 0; b0 = bursts;
        send_items(256, 1'b1);
        wait_drain();
        check("t2_bursts", bursts - b0, 2);
        check("t2_aw_wait", max_wait, 5);
        aw_delay = 0;

        // Data-channel stall drives the FIFO into overflow
        restart(32'h2100_0000);
        chk_en = 1'b0; wmode = 2;
        send_items(1000, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        check("t3_overflow_set", overflow, 1);
        check("t3_wvalid_held", m_axi_wvalid, 1);
        wmode = 0;
        pulse_aval(32'h2100_0000);
        t = 0;
        while (overflow && t < 3000) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #1;
        check("t3_overflow_clr", overflow, 0);
        check("t3_awaddr_reload", m_axi_awaddr, 32'h2100_0000);
        model_restart(32'h2100_0000);
        chk_en = 1'b1; b0 = bursts;
        send_items(128, 1'b1);
        wait_drain();
        check("t3_bursts_after", bursts - b0, 1);

        // Restart arriving mid-burst
        restart(32'h2100_0000);
        wmode = 1;
        send_items(128, 1'b1);
        t = 0;
        while (!(beat == 7 && m_axi_wvalid) && t < 2000) begin @(posedge clk); #1; t++; end
        check("t4_reach_beat7", (t < 2000), 1);
        b0 = b_hs;
        pulse_aval(32'h2200_0000);
        t = 0;
        while (b_hs == b0 && t < 2000) begin @(posedge clk); #1; t++; end
        repeat (5) @(posedge clk);
        #1;
        check("t4_burst_len", last_beats, 16);
        check("t4_awaddr_new", m_axi_awaddr, 32'h2200_0000);
        model_restart(32'h2200_0000);
        b0 = bursts;
        send_items(128, 1'b1);
        wait_drain();
        check("t4_bursts_after", bursts - b0, 1);

        // Frame end: items beyond SIZE are ignored
        restart(32'h2300_0000);
        b0 = bursts;
        send_items(SIZE + 76, 1'b1);
        wait_drain();
        check("t5_bursts", bursts - b0, SIZE / 128);
        repeat (50) @(posedge clk);
        #1;
        check("t5_no_extra_aw", m_axi_awvalid, 0);
        check("t5_bursts_final", bursts - b0, SIZE / 128);

        // Error response
        restart(32'h2100_0000);
        wmode = 0; resp_next = 2'b10;
        send_items(128, 1'b0);
        wait_drain();
`ifdef AXI_SINK_BRESP_CHECK_EN
        check("t6_err", err, 1);
`else
        check("t6_err", err, 0);
`endif
        resp_next = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
